// File: rtl/seq_serializer_pkg.sv
// Shared definitions for the serial front end: FSM state encodings and the default idle line level.
package seq_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic IDLE_BIT_DEFAULT = 1'b0;

endpackage

// File: rtl/ser_shreg.sv
// Load/shift register for the serializer; q presents the bit currently at the LSB.
module ser_shreg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q
);

    logic [WIDTH-1:0] r_shreg;

    // Load takes priority so a back-to-back frame replaces the finishing one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
        end else if (load) begin
            r_shreg <= d;
        end else if (shift) begin
            r_shreg <= r_shreg >> 1;
        end
    end

    assign q = r_shreg[0];

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: accepts {data, len} frames over valid/ready and emits them LSB-first.
module seq_serializer
    import seq_serializer_pkg::*;
#(
    parameter int   WIDTH    = 32,
    parameter int   LEN_W    = 6,
    parameter logic IDLE_BIT = IDLE_BIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    output logic             ser_out,
    output logic             ser_active,
    output logic             ser_last,
    output logic [LEN_W-1:0] bit_idx,
    output logic [7:0]       frame_cnt
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WIDTH);

    state_t           r_state;
    logic [LEN_W-1:0] r_remaining;
    logic [LEN_W-1:0] r_bit_idx;
    logic [7:0]       r_frame_cnt;

    logic             w_shifting;
    logic             w_last;
    logic             w_accept;
    logic [LEN_W-1:0] w_len_eff;
    logic             w_load;
    logic             w_shreg_q;

    assign w_shifting = (r_state == ST_SHIFT);
    assign w_last     = w_shifting && (r_remaining == LEN_W'(1));
    assign load_ready = !w_shifting || w_last;
    assign w_accept   = load_valid && load_ready;
    assign w_len_eff  = (load_len > MAX_LEN) ? MAX_LEN : load_len;
    // A zero-length frame is consumed by the handshake but never enters SHIFT.
    assign w_load     = w_accept && (w_len_eff != '0);

    ser_shreg #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .shift (w_shifting),
        .d     (load_data),
        .q     (w_shreg_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_bit_idx   <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (w_last) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            if (w_load) begin
                r_state     <= ST_SHIFT;
                r_remaining <= w_len_eff;
                r_bit_idx   <= '0;
            end else if (w_shifting) begin
                if (w_last) begin
                    r_state     <= ST_IDLE;
                    r_remaining <= '0;
                    r_bit_idx   <= '0;
                end else begin
                    r_remaining <= r_remaining - LEN_W'(1);
                    r_bit_idx   <= r_bit_idx + LEN_W'(1);
                end
            end
        end
    end

    assign ser_out    = w_shifting ? w_shreg_q : IDLE_BIT;
    assign ser_active = w_shifting;
    assign ser_last   = w_last;
    assign bit_idx    = r_bit_idx;
    assign frame_cnt  = r_frame_cnt;

endmodule
